// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: one shared tick-based delay timer, handed out round-robin.
// A requester holds req[i] high with its delay (in ticks) on req_delay; the winner is
// granted the timer, and its delay counts down once per PRESCALE clock cycles. When the
// delay expires, done[i] pulses for one cycle. Dropping req[i] while owning the timer
// aborts the job without a done pulse.
//
// Ports:
//   clk_in    - sole clock, rising edge
//   rst_n     - synchronous, active-HIGH reset (name kept for legacy compatibility)
//   req       - per-requester request, held until done or dropped to cancel
//   req_delay - requester i delay in ticks at [i*CNT_W +: CNT_W]
//   grant     - one-hot timer owner, zero when idle
//   done      - one-cycle completion pulse to the owner
//   busy      - high whenever not idle
//   tick_out  - one-cycle pulse per elapsed tick while counting
module tick_timer_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_delay,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     tick_out
);

  localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);
  localparam logic [PtrW-1:0]  LastIdx = PtrW'(NUM_REQ - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StCount = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PresW-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;

  logic               win_valid;
  logic [PtrW-1:0]    win_idx;
  logic [PtrW-1:0]    rr_idx;
  logic               owner_req;
  logic [CNT_W-1:0]   owner_delay;
  logic [PtrW-1:0]    owner_next;
  logic               tick_hit;

  // Round-robin pick: first asserted request scanning upward from ptr_q, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!win_valid && req[rr_idx]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  // Owner still holding its request; a drop means abort.
  assign owner_req   = |(req & grant_q);
  assign owner_delay = req_delay[32'(owner_q) * CNT_W +: CNT_W];
  assign owner_next  = (owner_q == LastIdx) ? '0 : owner_q + PtrW'(1);
  assign tick_hit    = (presc_q == PresMax);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StLoad;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      StLoad: begin
        if (!owner_req) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = owner_next;
        end else begin
          remaining_d = owner_delay;
          presc_d     = '0;
          state_d     = (owner_delay == '0) ? StDone : StCount;
        end
      end
      StCount: begin
        if (!owner_req) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = owner_next;
        end else if (tick_hit) begin
          presc_d = '0;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = owner_next;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      presc_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone) ? grant_q : '0;
  // Masked by owner_req so an abort in a tick cycle emits no tick.
  assign tick_out = (state_q == StCount) && tick_hit && owner_req;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter with NUM_REQ=4, PRESCALE=4, CNT_W=16.
// A per-cycle vector table covers reset, single job, zero delay, contention and
// fairness; hand-written sequences cover abort and reset during counting.
module tb_tick_timer_arbiter;

  localparam int NR = 4;
  localparam int PS = 4;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*CW-1:0]  dly = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
  logic              tick_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_timer_arbiter #(
    .NUM_REQ (NR),
    .PRESCALE(PS),
    .CNT_W   (CW)
  ) dut (
    .clk_in   (clk),
    .rst_n    (rst),
    .req      (req),
    .req_delay(dly),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .tick_out (tick_out)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] dly;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic        t;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] pk(int d3, int d2, int d1, int d0);
    return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
  endfunction

  function automatic void add(string tag, logic r, logic [3:0] rq, logic [63:0] dl,
                              logic [3:0] g, logic [3:0] d, logic b, logic t);
    vec_t v;
    v.tag = tag; v.rst = r; v.req = rq; v.dly = dl;
    v.g = g; v.d = d; v.b = b; v.t = t;
    vecs.push_back(v);
  endfunction

  // One job: IDLE sample cycle, LOAD, per tick (PS-1 quiet cycles + tick), then DONE.
  function automatic void add_job(string tag, logic [3:0] rq, logic [63:0] dl_load,
                                  logic [63:0] dl_run, logic [3:0] g, int ticks);
    add({tag, "_idle"}, 1'b0, rq, dl_load, 4'b0, 4'b0, 1'b0, 1'b0);
    add({tag, "_load"}, 1'b0, rq, dl_load, g, 4'b0, 1'b1, 1'b0);
    for (int i = 0; i < ticks; i++) begin
      for (int j = 0; j < PS - 1; j++) begin
        add({tag, "_cnt"}, 1'b0, rq, dl_run, g, 4'b0, 1'b1, 1'b0);
      end
      add({tag, "_tick"}, 1'b0, rq, dl_run, g, 4'b0, 1'b1, 1'b1);
    end
    add({tag, "_done"}, 1'b0, rq, dl_run, g, g, 1'b1, 1'b0);
  endfunction

  function automatic logic [9:0] outs();
    return {grant, done, busy, tick_out};
  endfunction

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got grant=%b done=%b busy=%b tick=%b, want grant=%b done=%b busy=%b tick=%b",
               name, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int found;
    int seen0;

    // ---- vector table ----
    add("reset", 1'b1, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    add("reset", 1'b1, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Single job, delay 3; all delays change after LOAD and must be ignored.
    add_job("single", 4'b0001, pk(9, 7, 5, 3), pk(2, 8, 6, 1), 4'b0001, 3);
    add("single_end", 1'b0, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Zero delay: done right after LOAD, no tick.
    add_job("zero", 4'b0010, pk(0, 0, 0, 0), pk(0, 0, 4, 0), 4'b0010, 0);
    add("zero_end", 1'b0, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Contention from reset: 0 then 2, requester 0 kept high.
    add("cont_reset", 1'b1, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    add_job("cont0", 4'b0101, pk(0, 1, 0, 1), pk(0, 1, 0, 1), 4'b0001, 1);
    add_job("cont2", 4'b0101, pk(0, 1, 0, 1), pk(0, 1, 0, 1), 4'b0100, 1);
    add("cont_end", 1'b0, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    // Fairness: all held, order 0,1,2,3,0.
    add("fair_reset", 1'b1, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      add_job("fair", 4'b1111, pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'(1 << (k % 4)), 1);
    end
    add("fair_end", 1'b0, 4'b0, 64'b0, 4'b0, 4'b0, 1'b0, 1'b0);

    step();
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      dly = vecs[i].dly;
      #1;
      check($sformatf("%s[%0d]", vecs[i].tag, i), outs(),
            {vecs[i].g, vecs[i].d, vecs[i].b, vecs[i].t});
      step();
    end

    // ---- abort: req[0] dropped at cycle 6 of a delay-5 job, req[1] pending ----
    rst = 1'b1; req = 4'b0; dly = '0;
    step();
    rst = 1'b0;
    req = 4'b0011;
    dly = pk(0, 0, 1, 5);
    #1 check("abort_c0", outs(), 10'b0);
    step();
    check("abort_c1", outs(), {4'b0001, 4'b0000, 1'b1, 1'b0});
    repeat (5) step();
    req = 4'b0010;
    #1 check("abort_c6", outs(), {4'b0001, 4'b0000, 1'b1, 1'b0});
    step();
    check("abort_c7_idle", outs(), 10'b0);
    step();
    check("abort_c8_grant", outs(), {4'b0010, 4'b0000, 1'b1, 1'b0});
    n = 8; found = 0; seen0 = 0;
    while (found == 0 && n < 40) begin
      step();
      n++;
      if (done[0]) seen0 = 1;
      if (done != 4'b0) found = 1;
    end
    check_int("abort_done_cycle", n, 13);
    check_int("abort_done_val", int'(done), 2);
    check_int("abort_no_done0", seen0, 0);
    req = 4'b0;
    step();
    check("abort_end", outs(), 10'b0);

    // ---- reset at cycle 7 of a delay-3 job, then req[3] with zero delay ----
    req = 4'b0001;
    dly = pk(0, 0, 0, 3);
    #1 check("rstmid_c0", outs(), 10'b0);
    step();
    check("rstmid_c1", outs(), {4'b0001, 4'b0000, 1'b1, 1'b0});
    repeat (6) step();
    rst = 1'b1;
    #1 check("rstmid_c7", outs(), {4'b0001, 4'b0000, 1'b1, 1'b0});
    step();
    rst = 1'b0;
    req = 4'b1000;
    #1 check("rstmid_c8_zero", outs(), 10'b0);
    step();
    check("rstmid_c9_grant", outs(), {4'b1000, 4'b0000, 1'b1, 1'b0});
    step();
    check("rstmid_c10_done", outs(), {4'b1000, 4'b1000, 1'b1, 1'b0});
    req = 4'b0;
    step();
    check("rstmid_c11_idle", outs(), 10'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
